// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver: FSM state encoding,
// default clocking and frame length.
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ_HZ = 12000000;
    localparam int DEFAULT_BAUD_RATE   = 115200;
    localparam int FRAME_BITS          = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Consumer-side bundle of the UART receiver: holding register, valid/ready
// handshake and the sticky error flags with their clear pulse.
interface uart_receiver_if;
    import uart_pkg::*;

    logic [FRAME_BITS-1:0] o_data;
    logic                  o_valid;
    logic                  i_ready;
    logic                  o_overrun;
    logic                  o_frame_err;
    logic                  i_clr_err;

    modport master (
        output o_data,
        output o_valid,
        output o_overrun,
        output o_frame_err,
        input  i_ready,
        input  i_clr_err
    );

    modport slave (
        input  o_data,
        input  o_valid,
        input  o_overrun,
        input  o_frame_err,
        output i_ready,
        output i_clr_err
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so a reset never fakes a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic resetn,
    input  logic rx_i,
    output logic rx_s_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    assign rx_s_o = sync_q[1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a one-deep holding register
// with valid/ready handshake and sticky overrun / framing-error flags.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
    parameter int BAUD_RATE   = DEFAULT_BAUD_RATE
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_rx,
    uart_receiver_if.master  bus
);

    localparam int DIV   = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = $clog2(FRAME_BITS);

    generate
        if (DIV < 4) begin : g_div_check
            $error("uart_receiver: CLK_FREQ_HZ/BAUD_RATE must be at least 4");
        end
    endgenerate

    logic rx_s;

    uart_rx_sync u_sync (
        .clk    (clk),
        .resetn (resetn),
        .rx_i   (i_rx),
        .rx_s_o (rx_s)
    );

    rx_state_e             state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [FRAME_BITS-1:0] data_q;
    logic                  valid_q;
    logic                  overrun_q;
    logic                  frame_err_q;

    logic sample;
    logic byte_done;
    logic stop_err;
    logic handshake;

    assign sample    = (cnt_q == '0);
    assign byte_done = (state_q == STOP) && sample && rx_s;
    assign stop_err  = (state_q == STOP) && sample && !rx_s;
    assign handshake = valid_q && bus.i_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // Half-bit preload puts every later sample near the bit centre.
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        cnt_q   <= CNT_W'(DIV / 2 - 1);
                    end
                end
                START: begin
                    if (sample) begin
                        cnt_q <= CNT_W'(DIV - 1);
                        if (rx_s) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= DATA;
                            idx_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (sample) begin
                        cnt_q          <= CNT_W'(DIV - 1);
                        shift_q[idx_q] <= rx_s;
                        if (idx_q == IDX_W'(FRAME_BITS - 1)) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                STOP: begin
                    if (sample) begin
                        cnt_q   <= CNT_W'(DIV - 1);
                        state_q <= rx_s ? IDLE : BREAK;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A completed byte only lands if the slot is free or draining now.
            if (byte_done) begin
                if (!valid_q || bus.i_ready) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end
            end else if (handshake) begin
                valid_q <= 1'b0;
            end

            if (bus.i_clr_err) begin
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end
            if (byte_done && valid_q && !bus.i_ready) begin
                overrun_q <= 1'b1;
            end
            if (stop_err) begin
                frame_err_q <= 1'b1;
            end
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_overrun   = overrun_q;
    assign bus.o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at DIV=10: bytes expected to be delivered
// are queued when sent and compared when the consumer handshake takes them.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int DIV    = CLK_HZ / BAUD;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic i_rx   = 1'b1;

    uart_receiver_if rx_bus ();

    uart_receiver #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD_RATE   (BAUD)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .i_rx   (i_rx),
        .bus    (rx_bus)
    );

    always #5 clk = ~clk;

    int         n_checks     = 0;
    int         n_errors     = 0;
    int         delivered    = 0;
    int         valid_cycles = 0;
    int         vc0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        i_rx = 1'b0;
        repeat (DIV) tick();
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (DIV) tick();
        end
        i_rx = stop;
        repeat (DIV) tick();
        i_rx = 1'b1;
    endtask

    task automatic pulse_ready();
        tick();
        rx_bus.i_ready = 1'b1;
        tick();
        rx_bus.i_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        tick();
        rx_bus.i_clr_err = 1'b1;
        tick();
        rx_bus.i_clr_err = 1'b0;
    endtask

    // Scoreboard side: every accepted transfer must match the oldest queued byte.
    always @(negedge clk) begin
        if (resetn && rx_bus.o_valid) begin
            valid_cycles++;
        end
        if (resetn && rx_bus.o_valid && rx_bus.i_ready) begin
            delivered++;
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_errors++;
                $error("FAIL unexpected_byte observed=0x%0h expected=none", rx_bus.o_data);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("rx_data", 32'(rx_bus.o_data), 32'(mon_exp));
                $display("xfer %0d data=0x%02h expected=0x%02h", delivered, rx_bus.o_data, mon_exp);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rx_bus.i_ready   = 1'b0;
        rx_bus.i_clr_err = 1'b0;
        i_rx             = 1'b1;
        resetn           = 1'b0;
        repeat (4) tick();

        @(negedge clk);
        check("rst_valid",     32'(rx_bus.o_valid),     32'd0);
        check("rst_data",      32'(rx_bus.o_data),      32'd0);
        check("rst_overrun",   32'(rx_bus.o_overrun),   32'd0);
        check("rst_frame_err", 32'(rx_bus.o_frame_err), 32'd0);
        check("rst_state",     32'(dut.state_q),        32'(IDLE));
        check("rst_sync",      32'(dut.u_sync.sync_q),  32'h3);
        tick();
        resetn = 1'b1;
        repeat (5) tick();

        // Single byte held until consumer takes it
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        repeat (DIV) tick();
        @(negedge clk);
        check("t1_valid",     32'(rx_bus.o_valid),     32'd1);
        check("t1_data",      32'(rx_bus.o_data),      32'h55);
        check("t1_overrun",   32'(rx_bus.o_overrun),   32'd0);
        check("t1_frame_err", 32'(rx_bus.o_frame_err), 32'd0);
        pulse_ready();
        @(negedge clk);
        check("t1_valid_drop", 32'(rx_bus.o_valid), 32'd0);
        check("t1_data_hold",  32'(rx_bus.o_data),  32'h55);

        // Overrun: second byte dropped, first kept
        exp_q.push_back(8'hA3);
        send_byte(8'hA3, 1'b1);
        send_byte(8'h0F, 1'b1);
        repeat (DIV) tick();
        @(negedge clk);
        check("t2_data",    32'(rx_bus.o_data),    32'hA3);
        check("t2_valid",   32'(rx_bus.o_valid),   32'd1);
        check("t2_overrun", 32'(rx_bus.o_overrun), 32'd1);
        pulse_clr();
        @(negedge clk);
        check("t2_overrun_clr", 32'(rx_bus.o_overrun), 32'd0);
        check("t2_valid_kept",  32'(rx_bus.o_valid),   32'd1);
        pulse_ready();
        @(negedge clk);
        check("t2_valid_drop", 32'(rx_bus.o_valid), 32'd0);

        // Framing error then recovery
        send_byte(8'h3C, 1'b0);
        repeat (2 * DIV) tick();
        @(negedge clk);
        check("t3_valid",     32'(rx_bus.o_valid),     32'd0);
        check("t3_frame_err", 32'(rx_bus.o_frame_err), 32'd1);
        check("t3_state",     32'(dut.state_q),        32'(IDLE));
        pulse_clr();
        @(negedge clk);
        check("t3_frame_clr", 32'(rx_bus.o_frame_err), 32'd0);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        repeat (DIV) tick();
        @(negedge clk);
        check("t3_valid_81",     32'(rx_bus.o_valid),     32'd1);
        check("t3_data_81",      32'(rx_bus.o_data),      32'h81);
        check("t3_frame_err_81", 32'(rx_bus.o_frame_err), 32'd0);
        pulse_ready();

        // Short low glitch on idle line
        tick();
        i_rx = 1'b0;
        repeat (3) tick();
        i_rx = 1'b1;
        repeat (3 * DIV) tick();
        @(negedge clk);
        check("t4_valid",     32'(rx_bus.o_valid),     32'd0);
        check("t4_overrun",   32'(rx_bus.o_overrun),   32'd0);
        check("t4_frame_err", 32'(rx_bus.o_frame_err), 32'd0);
        check("t4_state",     32'(dut.state_q),        32'(IDLE));

        // Reset during bit 4 of 0xFF
        tick();
        i_rx = 1'b0;
        repeat (DIV) tick();
        for (int i = 0; i < 4; i++) begin
            i_rx = 1'b1;
            repeat (DIV) tick();
        end
        repeat (DIV / 2) tick();
        resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        @(negedge clk);
        check("t5_state_rst", 32'(dut.state_q),    32'(IDLE));
        check("t5_valid_rst", 32'(rx_bus.o_valid), 32'd0);
        repeat (6 * DIV) tick();
        @(negedge clk);
        check("t5_no_phantom", 32'(rx_bus.o_valid), 32'd0);
        exp_q.push_back(8'h12);
        tick();
        send_byte(8'h12, 1'b1);
        repeat (DIV) tick();
        @(negedge clk);
        check("t5_valid_12", 32'(rx_bus.o_valid), 32'd1);
        check("t5_data_12",  32'(rx_bus.o_data),  32'h12);
        pulse_ready();

        // Ready held high across back-to-back bytes
        tick();
        vc0 = valid_cycles;
        rx_bus.i_ready = 1'b1;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        repeat (2 * DIV) tick();
        rx_bus.i_ready = 1'b0;
        @(negedge clk);
        check("t6_valid_cycles", 32'(valid_cycles - vc0), 32'd2);
        check("t6_overrun",      32'(rx_bus.o_overrun),   32'd0);
        check("t6_valid",        32'(rx_bus.o_valid),     32'd0);

        check("delivered_total", 32'(delivered),    32'd6);
        check("queue_empty",     32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
